// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO pointer width defaults, ptr_t, and Gray/binary conversion helpers
package fifo_pkg;
  localparam int PTR_WIDTH = 8;
  localparam int DATA_WIDTH = 8;
  typedef logic [PTR_WIDTH:0] ptr_t;
  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_WIDTH] = g[PTR_WIDTH];
    for (int i = PTR_WIDTH - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// fifo_wr_ctrl_if: producer valid/ready stream, async Gray read pointer, fifo_mem write port and fill status; master = producer side, slave = controller
interface fifo_wr_ctrl_if #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int PTR_WIDTH = fifo_pkg::PTR_WIDTH
);
  logic s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic s_ready;
  logic [PTR_WIDTH:0] g_rptr;
  logic w_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [PTR_WIDTH:0] b_wptr;
  logic [PTR_WIDTH:0] g_wptr;
  logic full;
  logic almost_full;
  logic half_full;
  logic [PTR_WIDTH:0] wr_level;
  logic [15:0] wr_count;
  modport master (
    output s_valid, s_data, g_rptr,
    input s_ready, w_en, data_in, b_wptr, g_wptr, full, almost_full, half_full, wr_level, wr_count
  );
  modport slave (
    input s_valid, s_data, g_rptr,
    output s_ready, w_en, data_in, b_wptr, g_wptr, full, almost_full, half_full, wr_level, wr_count
  );
endinterface

// File: rtl/fifo_sync_2ff.sv
// fifo_sync_2ff: two-flop synchroniser, d_i asynchronous in, q_o in wclk domain, both stages cleared by wrst_n
module fifo_sync_2ff #(
  parameter int WIDTH = fifo_pkg::PTR_WIDTH + 1
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] s1_q;
  always_ff @(posedge wclk)
    if (wrst_n) begin
      s1_q <= '0;
      q_o <= '0;
    end else begin
      s1_q <= d_i;
      q_o <= s1_q;
    end
endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: paces producer beats into fifo_mem on even-phase cycles, keeps write pointers, syncs read pointer, derives full/level/watermarks (ports: wclk, wrst_n, bus)
module fifo_wr_ctrl #(
  parameter int DEPTH = 2 ** fifo_pkg::PTR_WIDTH,
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int PTR_WIDTH = fifo_pkg::PTR_WIDTH,
  parameter int AF_MARGIN = 8
) (
  input logic          wclk,
  input logic          wrst_n,
  fifo_wr_ctrl_if.slave bus
);
  import fifo_pkg::*;
  localparam logic [PTR_WIDTH:0] AF_LVL = (PTR_WIDTH + 1)'(DEPTH - AF_MARGIN);
  localparam logic [PTR_WIDTH:0] HF_LVL = (PTR_WIDTH + 1)'(DEPTH / 2);
  logic phase_q, hold_valid_q;
  logic [DATA_WIDTH-1:0] hold_data_q;
  logic [PTR_WIDTH:0] b_wptr_q, b_wptr_d, g_wptr_q, wq2_rptr, wr_level;
  logic [15:0] wr_count_q;
  logic full, w_en, s_ready, accept;
  fifo_sync_2ff #(.WIDTH(PTR_WIDTH + 1)) u_sync (
    .wclk(wclk),
    .wrst_n(wrst_n),
    .d_i(bus.g_rptr),
    .q_o(wq2_rptr)
  );
  always_comb begin
    full = g_wptr_q == {~wq2_rptr[PTR_WIDTH:PTR_WIDTH-1], wq2_rptr[PTR_WIDTH-2:0]};
    w_en = hold_valid_q && !phase_q && !full;
    s_ready = !hold_valid_q || w_en;
    accept = bus.s_valid && s_ready;
    b_wptr_d = b_wptr_q + {{PTR_WIDTH{1'b0}}, w_en};
    wr_level = b_wptr_q - gray2bin(wq2_rptr);
  end
  always_ff @(posedge wclk)
    if (wrst_n) begin
      phase_q <= 1'b0;
      hold_valid_q <= 1'b0;
      b_wptr_q <= '0;
      g_wptr_q <= '0;
      wr_count_q <= '0;
    end else begin
      phase_q <= !phase_q;
      hold_valid_q <= accept || (hold_valid_q && !w_en);
      if (accept) hold_data_q <= bus.s_data;
      b_wptr_q <= b_wptr_d;
      g_wptr_q <= bin2gray(b_wptr_d);
      if (w_en && wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
    end
  assign bus.s_ready = s_ready;
  assign bus.w_en = w_en;
  assign bus.data_in = hold_data_q;
  assign bus.b_wptr = b_wptr_q;
  assign bus.g_wptr = g_wptr_q;
  assign bus.full = full;
  assign bus.almost_full = wr_level >= AF_LVL;
  assign bus.half_full = wr_level >= HF_LVL;
  assign bus.wr_level = wr_level;
  assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed stimulus with a count-based occupancy model compared against the DUT every cycle
module tb_fifo_wr_ctrl;
  logic wclk = 1'b0;
  logic wrst_n = 1'b1;
  fifo_wr_ctrl_if bus ();
  fifo_wr_ctrl dut (.wclk(wclk), .wrst_n(wrst_n), .bus(bus));
  always #5 wclk = ~wclk;
  int checks = 0;
  int failures = 0;
  bit armed = 0, last_wen = 0, seen_full = 0;
  bit m_ph, m_hold;
  logic [7:0] m_hd;
  int m_tot, m_rp1, m_rp2, rp;
  logic [7:0] dlog[$];
  logic [8:0] plog[$];
  logic [8:0] exp_p[4] = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // model view: occupancy = commits minus read pointer seen two edges ago; full means exactly DEPTH entries
  task automatic compare_all();
    int l, b;
    bit en;
    l = (m_tot - m_rp2) & 511;
    b = m_tot & 511;
    en = m_hold && !m_ph && l != 256;
    chk("s_ready", 32'(bus.s_ready), 32'(!m_hold || en));
    chk("w_en", 32'(bus.w_en), 32'(en));
    chk("b_wptr", 32'(bus.b_wptr), 32'(b));
    chk("g_wptr", 32'(bus.g_wptr), 32'(b ^ (b >> 1)));
    chk("full", 32'(bus.full), 32'(l == 256));
    chk("almost_full", 32'(bus.almost_full), 32'(l >= 248));
    chk("half_full", 32'(bus.half_full), 32'(l >= 128));
    chk("wr_level", 32'(bus.wr_level), 32'(l));
    chk("wr_count", 32'(bus.wr_count), 32'(m_tot > 65535 ? 65535 : m_tot));
    chk("wen_gap", 32'(bus.w_en && last_wen), 32'(0));
    if (bus.w_en === 1'b1) begin
      chk("data_in", 32'(bus.data_in), 32'(m_hd));
      dlog.push_back(bus.data_in);
      plog.push_back(bus.b_wptr);
    end
    last_wen = bus.w_en;
    if (bus.full === 1'b1) seen_full = 1;
  endtask

  task automatic model_step();
    int l;
    bit en, rdy, acc;
    if (wrst_n) begin
      m_ph = 0; m_hold = 0; m_tot = 0; m_rp1 = 0; m_rp2 = 0; armed = 1;
    end else begin
      l = (m_tot - m_rp2) & 511;
      en = m_hold && !m_ph && l != 256;
      rdy = !m_hold || en;
      acc = bus.s_valid && rdy;
      if (acc) m_hd = bus.s_data;
      m_hold = acc || (m_hold && !en);
      m_tot = m_tot + int'(en);
      m_rp2 = m_rp1;
      m_rp1 = rp;
      m_ph = !m_ph;
    end
  endtask

  task automatic tick();
    if (armed) compare_all();
    model_step();
    @(posedge wclk);
    @(negedge wclk);
  endtask

  task automatic send(input logic [7:0] d);
    bus.s_valid = 1'b1;
    bus.s_data = d;
    for (int i = 0; i < 8; i++) begin
      if (bus.s_ready === 1'b1) begin
        tick();
        bus.s_valid = 1'b0;
        return;
      end
      tick();
    end
    chk("send_timeout", 32'(bus.s_ready), 32'(1));
    bus.s_valid = 1'b0;
  endtask

  task automatic set_rp(input int v);
    rp = v;
    bus.g_rptr = 9'(v ^ (v >> 1));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_s_ready"}, 32'(bus.s_ready), 32'(1));
    chk({nm, "_w_en"}, 32'(bus.w_en), 32'(0));
    chk({nm, "_b_wptr"}, 32'(bus.b_wptr), 32'(0));
    chk({nm, "_g_wptr"}, 32'(bus.g_wptr), 32'(0));
    chk({nm, "_full"}, 32'(bus.full), 32'(0));
    chk({nm, "_af"}, 32'(bus.almost_full), 32'(0));
    chk({nm, "_hf"}, 32'(bus.half_full), 32'(0));
    chk({nm, "_level"}, 32'(bus.wr_level), 32'(0));
    chk({nm, "_count"}, 32'(bus.wr_count), 32'(0));
  endtask

  initial begin
    bus.s_valid = 1'b1;
    bus.s_data = 8'h55;
    set_rp(0);
    wrst_n = 1'b1;
    repeat (2) tick();
    chk_reset_vals("rst");
    bus.s_valid = 1'b0;
    wrst_n = 1'b0;
    repeat (3) tick();
    chk("rst_no_accept_count", 32'(bus.wr_count), 32'(0));
    chk("rst_no_accept_ptr", 32'(bus.b_wptr), 32'(0));
    dlog.delete();
    for (int i = 0; i < 4; i++) send(8'(8'hA0 + i));
    repeat (4) tick();
    chk("stream_b_wptr", 32'(bus.b_wptr), 32'(4));
    chk("stream_count", 32'(bus.wr_count), 32'(4));
    chk("stream_nwrites", 32'(dlog.size()), 32'(4));
    for (int i = 0; i < 4 && i < dlog.size(); i++) chk("stream_data", 32'(dlog[i]), 32'(8'hA0 + i));
    wrst_n = 1'b1;
    tick();
    wrst_n = 1'b0;
    for (int i = 0; i < 257; i++) send(8'(i));
    repeat (3) tick();
    chk("fill_full", 32'(bus.full), 32'(1));
    chk("fill_b_wptr", 32'(bus.b_wptr), 32'(9'h100));
    chk("fill_g_wptr", 32'(bus.g_wptr), 32'(9'h180));
    chk("fill_level", 32'(bus.wr_level), 32'(256));
    chk("fill_s_ready", 32'(bus.s_ready), 32'(0));
    chk("fill_w_en", 32'(bus.w_en), 32'(0));
    chk("fill_af", 32'(bus.almost_full), 32'(1));
    chk("fill_count", 32'(bus.wr_count), 32'(256));
    set_rp(16);
    tick();
    chk("drain_full_edge1", 32'(bus.full), 32'(1));
    tick();
    chk("drain_full_edge2", 32'(bus.full), 32'(0));
    repeat (3) tick();
    chk("drain_level", 32'(bus.wr_level), 32'(241));
    chk("drain_b_wptr", 32'(bus.b_wptr), 32'(9'h101));
    chk("drain_s_ready", 32'(bus.s_ready), 32'(1));
    set_rp(0);
    wrst_n = 1'b1;
    repeat (2) tick();
    wrst_n = 1'b0;
    for (int i = 0; i < 510; i++) begin
      send(8'(i));
      set_rp(i);
    end
    repeat (4) tick();
    set_rp(510);
    repeat (4) tick();
    chk("wrap_pre_b_wptr", 32'(bus.b_wptr), 32'(9'h1FE));
    chk("wrap_pre_level", 32'(bus.wr_level), 32'(0));
    plog.delete();
    seen_full = 0;
    for (int i = 0; i < 4; i++) send(8'(8'hB0 + i));
    repeat (4) tick();
    chk("wrap_nwrites", 32'(plog.size()), 32'(4));
    for (int i = 0; i < 4 && i < plog.size(); i++) chk("wrap_ptr_seq", 32'(plog[i]), 32'(exp_p[i]));
    chk("wrap_b_wptr", 32'(bus.b_wptr), 32'(9'h002));
    chk("wrap_level", 32'(bus.wr_level), 32'(4));
    chk("wrap_no_full", 32'(seen_full), 32'(0));
    for (int i = 0; i < 6; i++) send(8'(8'hC0 + i));
    repeat (4) tick();
    chk("mid_level", 32'(bus.wr_level), 32'(10));
    bus.s_valid = 1'b1;
    bus.s_data = 8'hEE;
    tick();
    bus.s_valid = 1'b0;
    set_rp(0);
    wrst_n = 1'b1;
    tick();
    chk_reset_vals("mid_rst");
    wrst_n = 1'b0;
    repeat (3) tick();
    chk("mid_discard_ptr", 32'(bus.b_wptr), 32'(0));
    chk("mid_discard_count", 32'(bus.wr_count), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
